// File: rtl/ks10_fifo.sv
// Single-clock show-ahead FIFO with level, almost-full and optional sticky error flags.
// Define FIFO_ERRFLAGS_EN to build the ovf/unf flag registers; otherwise both are tied low.
module ks10_fifo #(
  parameter int SIZE      = 64,
  parameter int WIDTH     = 16,
  parameter int AFULL_LVL = 48
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clken,
  input  logic                   clr,
  input  logic                   wr,
  input  logic                   rd,
  input  logic [WIDTH-1:0]       in,
  output logic [WIDTH-1:0]       out,
  output logic                   full,
  output logic                   empty,
  output logic                   alm_full,
  output logic [$clog2(SIZE):0]  level,
  output logic                   ovf,
  output logic                   unf
);

  localparam int AW      = $clog2(SIZE);
  localparam int BUFSIZE = 1 << AW;

  localparam logic [AW-1:0] PTR_ONE   = AW'(1'b1);
  localparam logic [AW:0]   LVL_ONE   = (AW+1)'(1'b1);
  localparam logic [AW:0]   LVL_FULL  = (AW+1)'(BUFSIZE);
  localparam logic [AW:0]   LVL_AFULL = (AW+1)'(AFULL_LVL);

  logic [WIDTH-1:0] mem_r [BUFSIZE];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      level_r;
  logic [AW:0]      level_nxt_s;
  logic             op_en_s;
  logic             rd_ok_s;
  logic             wr_ok_s;
  logic             full_s;
  logic             empty_s;

  assign full_s   = (level_r == LVL_FULL);
  assign empty_s  = (level_r == {(AW+1){1'b0}});
  // A pending clear suppresses both transfers for that cycle.
  assign op_en_s  = clken & ~clr;
  assign rd_ok_s  = op_en_s & rd & ~empty_s;
  assign wr_ok_s  = op_en_s & wr & (~full_s | rd_ok_s);

  assign out      = mem_r[rd_ptr_r];
  assign full     = full_s;
  assign empty    = empty_s;
  assign alm_full = (level_r >= LVL_AFULL);
  assign level    = level_r;

  // Occupancy moves only when exactly one side transfers.
  always_comb begin
    level_nxt_s = level_r;
    case ({wr_ok_s, rd_ok_s})
      2'b10:   level_nxt_s = level_r + LVL_ONE;
      2'b01:   level_nxt_s = level_r - LVL_ONE;
      default: level_nxt_s = level_r;
    endcase
  end

  // Pointer and level registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {(AW+1){1'b0}};
    end else if (clken && clr) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {(AW+1){1'b0}};
    end else begin
      if (wr_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (rd_ok_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
      level_r <= level_nxt_s;
    end
  end

  // Storage array; deliberately not reset.
  always_ff @(posedge clk) begin
    if (rst && wr_ok_s) begin
      mem_r[wr_ptr_r] <= in;
    end
  end

`ifdef FIFO_ERRFLAGS_EN
  logic ovf_r;
  logic unf_r;
  logic ovf_set_s;
  logic unf_set_s;

  assign ovf_set_s = op_en_s & wr & full_s & ~rd_ok_s;
  assign unf_set_s = op_en_s & rd & empty_s;

  // Sticky error flags, cleared only by reset or clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else if (clken && clr) begin
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else begin
      if (ovf_set_s) ovf_r <= 1'b1;
      if (unf_set_s) unf_r <= 1'b1;
    end
  end

  assign ovf = ovf_r;
  assign unf = unf_r;
`else
  assign ovf = 1'b0;
  assign unf = 1'b0;
`endif

endmodule

// File: tb/tb_ks10_fifo.sv
// Scoreboard bench for ks10_fifo (SIZE=64, WIDTH=16, AFULL_LVL=48).
module tb_ks10_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clken = 1'b1;
  logic        clr = 1'b0;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic [15:0] din = 16'h0000;
  logic [15:0] dout;
  logic        full, empty, alm_full, ovf, unf;
  logic [6:0]  level;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [15:0] q[$];
  logic        m_ovf = 1'b0;
  logic        m_unf = 1'b0;

  ks10_fifo #(.SIZE(64), .WIDTH(16), .AFULL_LVL(48)) dut (
    .clk(clk), .rst(rst), .clken(clken), .clr(clr), .wr(wr), .rd(rd),
    .in(din), .out(dout), .full(full), .empty(empty), .alm_full(alm_full),
    .level(level), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  function automatic logic exp_ovf();
`ifdef FIFO_ERRFLAGS_EN
    return m_ovf;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic exp_unf();
`ifdef FIFO_ERRFLAGS_EN
    return m_unf;
`else
    return 1'b0;
`endif
  endfunction

  // Drive one cycle and advance the reference model; no checking here.
  task automatic step(input logic w, input logic r, input logic [15:0] d,
                      input logic ce, input logic cl);
    logic r_ok, w_ok;
    wr = w; rd = r; din = d; clken = ce; clr = cl;
    if (ce) begin
      if (cl) begin
        q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
      end else begin
        r_ok = r && (q.size() > 0);
        w_ok = w && ((q.size() < 64) || r_ok);
        if (w && q.size() == 64 && !r_ok) m_ovf = 1'b1;
        if (r && q.size() == 0) m_unf = 1'b1;
        if (r_ok) void'(q.pop_front());
        if (w_ok) q.push_back(d);
      end
    end
    @(posedge clk); #1;
    wr = 1'b0; rd = 1'b0; clr = 1'b0; clken = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; wr = 1'b1; din = 16'h5555; clken = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1; wr = 1'b0;
    q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%b exp=1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b exp=0", full); end
    n_cmp++; if (alm_full !== 1'b0) begin n_fail++; $display("FAIL reset_afull got=%b exp=0", alm_full); end
    n_cmp++; if (level !== 7'd0) begin n_fail++; $display("FAIL reset_level got=%0d exp=0", level); end
    n_cmp++; if (ovf !== 1'b0 || unf !== 1'b0) begin n_fail++; $display("FAIL reset_flags got=%b%b exp=00", ovf, unf); end
  endtask

  task automatic test_order();
    logic [15:0] exp;
    for (int i = 1; i <= 64; i++) begin
      step(1'b1, 1'b0, 16'(i), 1'b1, 1'b0);
      n_cmp++; if (level !== 7'(q.size())) begin n_fail++; $display("FAIL order_level got=%0d exp=%0d", level, q.size()); end
      n_cmp++; if (alm_full !== (i >= 48)) begin n_fail++; $display("FAIL order_afull i=%0d got=%b exp=%b", i, alm_full, (i >= 48)); end
      n_cmp++; if (full !== (i == 64)) begin n_fail++; $display("FAIL order_full i=%0d got=%b exp=%b", i, full, (i == 64)); end
    end
    for (int i = 1; i <= 64; i++) begin
      exp = q[0];
      n_cmp++; if (dout !== exp) begin n_fail++; $display("FAIL order_data got=%h exp=%h", dout, exp); end
      n_cmp++; if (exp !== 16'(i)) begin n_fail++; $display("FAIL order_model got=%h exp=%h", exp, 16'(i)); end
      step(1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    end
    n_cmp++; if (empty !== 1'b1 || level !== 7'd0) begin n_fail++; $display("FAIL order_drained empty=%b level=%0d exp=1/0", empty, level); end
  endtask

  task automatic test_full_boundary();
    logic [15:0] exp;
    for (int i = 0; i < 64; i++) step(1'b1, 1'b0, 16'h1000 + 16'(i), 1'b1, 1'b0);
    n_cmp++; if (full !== 1'b1) begin n_fail++; $display("FAIL full_set got=%b exp=1", full); end
    step(1'b1, 1'b0, 16'hDEAD, 1'b1, 1'b0);
    n_cmp++; if (level !== 7'd64) begin n_fail++; $display("FAIL full_drop_level got=%0d exp=64", level); end
    n_cmp++; if (ovf !== exp_ovf()) begin n_fail++; $display("FAIL full_ovf got=%b exp=%b", ovf, exp_ovf()); end
    n_cmp++; if (dout !== 16'h1000) begin n_fail++; $display("FAIL full_head got=%h exp=1000", dout); end
    step(1'b1, 1'b1, 16'hBEEF, 1'b1, 1'b0);
    n_cmp++; if (level !== 7'd64 || full !== 1'b1) begin n_fail++; $display("FAIL full_rw level=%0d full=%b exp=64/1", level, full); end
    exp = 16'h0000;
    for (int i = 0; i < 64; i++) begin
      exp = q[0];
      n_cmp++; if (dout !== exp) begin n_fail++; $display("FAIL full_drain got=%h exp=%h", dout, exp); end
      step(1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    end
    n_cmp++; if (exp !== 16'hBEEF) begin n_fail++; $display("FAIL full_last got=%h exp=beef", exp); end
  endtask

  task automatic test_empty_boundary();
    step(1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    n_cmp++; if (level !== 7'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL empty_rd level=%0d empty=%b exp=0/1", level, empty); end
    n_cmp++; if (unf !== exp_unf()) begin n_fail++; $display("FAIL empty_unf got=%b exp=%b", unf, exp_unf()); end
    step(1'b1, 1'b1, 16'h1234, 1'b1, 1'b0);
    n_cmp++; if (level !== 7'd1) begin n_fail++; $display("FAIL empty_rw_level got=%0d exp=1", level); end
    n_cmp++; if (dout !== 16'h1234) begin n_fail++; $display("FAIL empty_rw_data got=%h exp=1234", dout); end
    step(1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL empty_drain got=%b exp=1", empty); end
  endtask

  task automatic test_wrap_clear();
    logic w, r, ce;
    for (int i = 0; i < 200; i++) begin
      w  = ($urandom_range(0, 9) < 6);
      r  = ($urandom_range(0, 9) < 4);
      ce = ($urandom_range(0, 4) != 0);
      if (q.size() > 0) begin
        n_cmp++; if (dout !== q[0]) begin n_fail++; $display("FAIL rnd_data i=%0d got=%h exp=%h", i, dout, q[0]); end
      end
      step(w, r, 16'($urandom), ce, 1'b0);
      n_cmp++; if (level !== 7'(q.size())) begin n_fail++; $display("FAIL rnd_level i=%0d got=%0d exp=%0d", i, level, q.size()); end
      n_cmp++; if (full !== (q.size() == 64) || empty !== (q.size() == 0)) begin n_fail++; $display("FAIL rnd_flags i=%0d full=%b empty=%b size=%0d", i, full, empty, q.size()); end
      n_cmp++; if (ovf !== exp_ovf() || unf !== exp_unf()) begin n_fail++; $display("FAIL rnd_err i=%0d got=%b%b exp=%b%b", i, ovf, unf, exp_ovf(), exp_unf()); end
      if (i == 100) begin
        step(1'b1, 1'b1, 16'h7777, 1'b0, 1'b1);
        n_cmp++; if (level !== 7'(q.size())) begin n_fail++; $display("FAIL clr_gated got=%0d exp=%0d", level, q.size()); end
        step(1'b1, 1'b1, 16'h7777, 1'b1, 1'b1);
        n_cmp++; if (level !== 7'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL clr_level level=%0d empty=%b exp=0/1", level, empty); end
        n_cmp++; if (ovf !== 1'b0 || unf !== 1'b0) begin n_fail++; $display("FAIL clr_flags got=%b%b exp=00", ovf, unf); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_order();
    test_full_boundary();
    test_empty_boundary();
    test_wrap_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
